bin_to_bcd_serial: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that sits directly upstream of the 4-digit seven-segment display stage.
- Accepts a 16-bit unsigned value on a start strobe and clamps it to MAX_VALUE.
- Produces four packed BCD digits plus an overflow flag after a fixed 16-shift conversion.
- Replaces per-digit divide/modulo logic with a small iterative datapath. Intended to be kicked by the same periodic tick that refreshes the display.

---
 rtl/bin_to_bcd_serial.sv | 97 +++++++++
 tb/tb_bin_to_bcd_serial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_serial
//  Brief    : Sequential 16-bit binary to 4-digit packed BCD converter using
//             shift-and-add-3 (double dabble). The input is clamped to
//             MAX_VALUE, and an overflow flag records when clamping happened.
//             The result is held stable between conversions.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_serial #(
   parameter int unsigned MAX_VALUE = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd_out,
   output logic        overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [15:0] MAX_V = 16'(MAX_VALUE);

   state_t      state;
   logic [15:0] bin_sr;       // binary operand, shifted out MSB first
   logic [15:0] acc;          // BCD accumulator, four nibbles
   logic [4:0]  count;        // shift iterations remaining
   logic        ovf_pending;  // clamp flag for the conversion in flight
   logic [15:0] acc_adj;      // accumulator after the add-3 correction

   // Add 3 to every nibble that is 5 or more, all from pre-adjust values.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 4; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // busy reflects only the shifting phase; the done cycle reads as idle.
   assign busy = (state == SHIFT);

   // Conversion FSM: capture, 16 shift iterations, then publish the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bin_sr      <= 16'h0000;
         acc         <= 16'h0000;
         count       <= 5'd0;
         ovf_pending <= 1'b0;
         done        <= 1'b0;
         bcd_out     <= 16'h0000;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr      <= (bin_in > MAX_V) ? MAX_V : bin_in;
                  ovf_pending <= (bin_in > MAX_V);
                  acc         <= 16'h0000;
                  count       <= 5'd16;
                  state       <= SHIFT;
               end
            end
            SHIFT: begin
               // {acc, bin_sr} shifts left as one 32-bit unit.
               acc    <= {acc_adj[14:0], bin_sr[15]};
               bin_sr <= {bin_sr[14:0], 1'b0};
               count  <= count - 5'd1;
               if (count == 5'd1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done     <= 1'b1;
               bcd_out  <= acc;
               overflow <= ovf_pending;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_serial
//  Brief    : Scoreboard bench for bin_to_bcd_serial. The stimulus pushes the
//             expected result and done cycle for each accepted start; a forked
//             monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_serial;

   localparam int unsigned MAX_VALUE = 9999;

   typedef struct packed {
      logic [15:0] bcd;
      logic        ovf;
      logic [31:0] dc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] bin_in = 16'h0000;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        overflow;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   bin_to_bcd_serial #(.MAX_VALUE(MAX_VALUE)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .bcd_out  (bcd_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Free-running edge counter used to time done pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: clamp, then decimal digits by plain division.
   function automatic logic [16:0] model(input int unsigned v);
      int unsigned m;
      m = (v > MAX_VALUE) ? MAX_VALUE : v;
      return {(v > MAX_VALUE) ? 1'b1 : 1'b0,
              4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Called just after a falling edge: raise start for one rising edge.
   task automatic issue(input logic [15:0] v);
      logic [16:0] r;
      exp_t        e;
      r      = model(32'(v));
      start  = 1'b1;
      bin_in = v;
      e.bcd  = r[15:0];
      e.ovf  = r[16];
      e.dc   = 32'(cyc + 18);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      logic [15:0] bvals [6];
      int          n0;
      bvals = '{16'd0, 16'd9, 16'd10, 16'd9999, 16'd10000, 16'd65535};

      // Monitor: compare every done pulse against the scoreboard head.
      fork
         forever begin
            @(negedge clk);
            if (done) begin
               exp_t e;
               done_cnt++;
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                  chk("overflow", 32'(overflow), 32'(e.ovf));
                  chk("done_cycle", 32'(cyc), e.dc);
                  chk("busy_in_done", 32'(busy), 32'd0);
               end
            end
         end
      join_none

      // Reset and idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_bcd", 32'(bcd_out), 32'd0);
         chk("idle_ovf", 32'(overflow), 32'd0);
      end

      // 1234: busy profile, single done, then holding.
      issue(16'd1234);
      for (int i = 0; i < 16; i++) begin
         chk("busy_high", 32'(busy), 32'd1);
         @(negedge clk);
      end
      chk("busy_low_end", 32'(busy), 32'd0);
      chk("no_early_done", 32'(done), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_done", 32'(done), 32'd0);
         chk("hold_bcd", 32'(bcd_out), 32'h1234);
         chk("hold_ovf", 32'(overflow), 32'd0);
      end
      wait_idle();

      // Boundary values.
      foreach (bvals[k]) begin
         @(negedge clk);
         issue(bvals[k]);
         wait_idle();
      end

      // Restarts while busy are ignored; late bin_in changes have no effect.
      @(negedge clk);
      n0 = done_cnt;
      issue(16'd4321);
      repeat (2) @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      chk("single_done", 32'(done_cnt - n0), 32'd1);
      wait_idle();

      // Back-to-back: second start lands in the done cycle.
      @(negedge clk);
      issue(16'd42);
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         @(negedge clk);
      end
      chk("b2b_done_seen", 32'(done), 32'd1);
      issue(16'd815);
      wait_idle();

      // Reset aborts a conversion in progress.
      @(negedge clk);
      issue(16'd1111);
      wait_idle();
      @(negedge clk);
      issue(16'd5678);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_bcd", 32'(bcd_out), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      void'(sb.pop_back());
      reset = 1'b0;
      n0 = done_cnt;
      repeat (30) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - n0), 32'd0);
      issue(16'd5678);
      wait_idle();

      // Random sweep.
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] v;
         v = (i % 4 == 0) ? 16'($urandom_range(0, 12000)) : 16'($urandom_range(0, 65535));
         @(negedge clk);
         issue(v);
         wait_idle();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
